data_mem_arbiter: RTL
=====================

# data_mem_arbiter

Two-requester arbiter and access sequencer in front of `Data_Memory`. It shares the single data memory between the core load/store path (requester 0) and a debug/DMA port (requester 1). Each requester uses a valid/ready request channel and a one-cycle response pulse. The block drives every `Data_Memory` input and registers its read data, so every access has a fixed, registered latency.

## Interface
Parameters:
- `ADDR_W`, 32, byte address width driven onto `alu_result`.
- `DATA_W`, 32, data width. Must equal 32.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `mN_req_valid`  in  1  request present (N = 0, 1).
- `mN_req_ready`  out  1  request accepted this cycle when `valid && ready`.
- `mN_req_we`  in  1  1 = store, 0 = load.
- `mN_req_funct3`  in  3  RV32I width code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `mN_req_addr`  in  ADDR_W  byte address.
- `mN_req_wdata`  in  32  store data, right-aligned.
- `mN_rsp_valid`  out  1  one-cycle response pulse.
- `mN_rsp_rdata`  out  32  load result, extended by `Data_Memory`; 0 for stores and errors.
- `mN_rsp_err`  out  1  misaligned or illegal funct3. Valid with `rsp_valid`.
- `mem_read`, `mem_write`  out  1  `Data_Memory` strobes.
- `alu_result`  out  32  memory address.
- `rs2_data`  out  32  memory write data.
- `instruction`  out  32  synthesized word: funct3 in [14:12], all other bits 0.
- `data_mem_data`  in  32  combinational read data from `Data_Memory`.

## Operation
- FSM states:
  - IDLE: accept a request.
  - ACCESS: drive memory for exactly one cycle.
  - RESP: pulse the response.
- Transitions: IDLE→ACCESS on a handshake; ACCESS→RESP always; RESP→IDLE always.
- `mN_req_ready` is high only in IDLE, and only for the granted requester. It may depend combinationally on `mN_req_valid`.
- Arbitration in IDLE:
  - Only one valid: that requester wins.
  - Both valid: grant goes to the requester not in `last_grant`.
  - `last_grant` updates on each handshake and resets to 1, so m0 wins the first tie.
- On handshake, register `we`, `funct3`, `addr`, `wdata` and the grant index. The requester may change its inputs on the next cycle.
- Legality check is done at accept time and registered as `err`:
  - Loads: funct3 ∈ {000, 001, 010, 100, 101}.
  - Stores: funct3 ∈ {000, 001, 010}.
  - Halfword: `addr[0]` = 0. Word: `addr[1:0]` = 0.
- ACCESS with `err` = 0: assert `mem_write` = `we` or `mem_read` = !`we`. `alu_result`, `rs2_data` and `instruction` come from the registered request. Load data is captured at the end of ACCESS.
- ACCESS with `err` = 1: no strobes, and memory is untouched.
- RESP: the granted requester's `rsp_valid` = 1 for one cycle. `rdata` = captured data if (load && !err), else 0. The other requester's `rsp_valid` stays 0.
- `mem_read`/`mem_write` are 0 in IDLE and RESP. Address, data and instruction outputs hold their last registered value.

## Timing
- Handshake in cycle T → strobes in T+1 (store commits at the T+1→T+2 edge) → `rsp_valid` in T+2 → next accept earliest in T+3.
- Throughput is one transaction per 3 cycles.
- There is no response backpressure; requesters must sink `rsp_valid` when it arrives.
- Reset values:
  - state = IDLE, `last_grant` = 1.
  - All `req_ready`, `rsp_valid`, `rsp_err`, `mem_read`, `mem_write` = 0.
  - `rsp_rdata`, `alu_result`, `rs2_data`, `instruction` = 0.
- Reset mid-transaction: the FSM returns to IDLE on that edge and strobes are 0 from the next cycle. The in-flight transaction gets no response. A store whose ACCESS cycle coincides with the reset edge is not guaranteed to commit.
- A request held valid while the other requester is in flight stays pending; it is not dropped.

## Structure
- Package `dmem_pkg`:
  - FSM state enum.
  - funct3 constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - `FUNCT3_LSB` = 12.
  - Legality function `dmem_access_legal(we, funct3, addr[1:0])`.
- Sub-module `dmem_rr_arb`: 2-way round-robin grant, inputs `valid[1:0]` and `last_grant`, output one-hot `grant`. Everything else is inline.

## Test plan
- **Single store then load, m0:** sw 0x12345678 @0x8, then lw @0x8.
  - `mem_write` high for exactly one cycle at T+1.
  - Load response at T+2 has rdata 0x12345678, err 0.
- **Sign/zero extension:** sb 0xA5 @0x0, then lb and lbu @0x0.
  - lb returns 0xFFFFFFA5; lbu returns 0x000000A5.
- **Simultaneous requests:** both valid from reset, held for several transactions.
  - Grants m0, m1, m0, m1.
  - Exactly one `rsp_valid` per transaction, routed to the correct requester.
- **Misaligned access:** lw @0x6 and sh @0x3.
  - No memory strobe during ACCESS.
  - `rsp_err` = 1, rdata 0; a following lw @0x4 still returns the prior contents.
- **Illegal funct3:** store with funct3 100.
  - `rsp_err` = 1 and memory is unchanged.
- **Reset during ACCESS of an m1 load:** assert `rst` for one cycle.
  - No `m1_rsp_valid`, and all outputs are at reset values.
  - A new m0 request is accepted in the first cycle after reset.

Source files
------------

// File: rtl/data_mem_arbiter_pkg.sv
// dmem_pkg: shared types and helpers for the data memory arbiter.
// Holds the FSM encoding, RV32I width codes and the legality check.
package dmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int FUNCT3_LSB = 12;

  function automatic logic dmem_access_legal(
    input logic       we,
    input logic [2:0] funct3,
    input logic [1:0] addr_lo
  );
    logic ok;
    ok = 1'b0;
    unique case (funct3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = !addr_lo[0];
      F3_W:    ok = (addr_lo == 2'b00);
      F3_BU:   ok = !we;
      F3_HU:   ok = !we && !addr_lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// dmem_req_if: one requester's valid/ready request channel
// plus its single-cycle response pulse.
interface dmem_req_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_funct3,
    output req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3,
    input  req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_arbiter_rr_arb.sv
// dmem_rr_arb: 2-way round-robin grant.
// On a tie the requester that did not win last time is chosen.
module dmem_rr_arb (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // one-hot grant from current requests and previous winner
  always_comb begin
    grant = 2'b00;
    unique case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares Data_Memory between two requesters.
// Each transaction runs accept -> access -> respond, 3 cycles.
module data_mem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  dmem_req_if.slave   m0,
  dmem_req_if.slave   m1,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] alu_result,
  output logic [31:0] rs2_data,
  output logic [31:0] instruction,
  input  logic [31:0] data_mem_data
);

  state_e state_q, state_d;

  logic [1:0] valid;
  logic [1:0] grant;
  logic       idle;
  logic       hs;
  logic       sel;
  logic       rsp_fire;

  logic              req_we;
  logic [2:0]        req_f3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              we_q;
  logic              err_q;
  logic              gnt_q;
  logic              last_grant_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  assign valid = {m1.req_valid, m0.req_valid};

  dmem_rr_arb u_arb (
    .valid      (valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  assign idle = (state_q == S_IDLE);
  assign hs   = idle && (grant != 2'b00);
  assign sel  = grant[1];

  assign m0.req_ready = idle && grant[0];
  assign m1.req_ready = idle && grant[1];

  assign req_we    = sel ? m1.req_we     : m0.req_we;
  assign req_f3    = sel ? m1.req_funct3 : m0.req_funct3;
  assign req_addr  = sel ? m1.req_addr   : m0.req_addr;
  assign req_wdata = sel ? m1.req_wdata  : m0.req_wdata;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next state, memory strobes and response fire
  always_comb begin
    state_d   = state_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    rsp_fire  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (hs) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        state_d   = S_RESP;
        mem_read  = !err_q && !we_q;
        mem_write = !err_q && we_q;
      end
      S_RESP: begin
        state_d  = S_IDLE;
        rsp_fire = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // latch the winning request and its legality at accept
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      f3_q         <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else if (hs) begin
      we_q         <= req_we;
      err_q        <= !dmem_access_legal(req_we, req_f3,
                                         req_addr[1:0]);
      gnt_q        <= sel;
      last_grant_q <= sel;
      f3_q         <= req_f3;
      addr_q       <= req_addr;
      wdata_q      <= req_wdata;
    end
  end

  // capture load data at the end of the access cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (state_q == S_ACCESS) begin
      rdata_q <= (!we_q && !err_q) ? data_mem_data : '0;
    end
  end

  assign alu_result  = 32'(addr_q);
  assign rs2_data    = 32'(wdata_q);
  assign instruction = 32'(f3_q) << FUNCT3_LSB;

  assign m0.rsp_valid = rsp_fire && !gnt_q;
  assign m1.rsp_valid = rsp_fire && gnt_q;
  assign m0.rsp_rdata = m0.rsp_valid ? 32'(rdata_q) : 32'd0;
  assign m1.rsp_rdata = m1.rsp_valid ? 32'(rdata_q) : 32'd0;
  assign m0.rsp_err   = m0.rsp_valid && err_q;
  assign m1.rsp_err   = m1.rsp_valid && err_q;

endmodule
